// File: rtl/accum_alu_pkg.sv
// Shared opcode encoding, output-stage state type and channel-width helper
// for the accumulator ALU.
package accum_alu_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accum_alu_core.sv
// Combinational unsigned add/subtract with carry/borrow flag and optional
// clamping to the representable range.
module accum_alu_core #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    // Top bit of the widened difference is set exactly when a_i < b_i.
    diff  = {1'b0, a_i} - {1'b0, b_i};
    res_o = '0;
    ovf_o = 1'b0;
    if (sub_i) begin
      ovf_o = diff[WIDTH];
      res_o = diff[WIDTH-1:0];
      if ((SATURATE != 0) && diff[WIDTH]) begin
        res_o = '0;
      end
    end else begin
      ovf_o = sum[WIDTH];
      res_o = sum[WIDTH-1:0];
      if ((SATURATE != 0) && sum[WIDTH]) begin
        res_o = '1;
      end
    end
  end

endmodule

// File: rtl/accum_alu.sv
// Single-stage ALU with per-channel accumulators and a one-entry
// valid/ready output register.
module accum_alu
  import accum_alu_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_CH   = 4,
  parameter  int SATURATE = 0,
  localparam int CHW      = ch_width(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [CHW-1:0]   in_ch,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CHW-1:0]   out_ch
);

  localparam logic [CHW:0] NUM_CH_W = (CHW + 1)'(NUM_CH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [WIDTH-1:0] acc_q [NUM_CH];

  op_e              op;
  logic             ch_ok;
  logic [CHW-1:0]   ch_idx;
  logic [WIDTH-1:0] acc_rd;
  logic [WIDTH-1:0] core_a, core_b, core_res;
  logic             core_sub, core_ovf;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic             acc_we;
  logic [WIDTH-1:0] acc_wdata;
  logic             xfer_in, xfer_out;

  assign op        = op_e'(in_op);
  assign ch_ok     = ({1'b0, in_ch} < NUM_CH_W);
  assign ch_idx    = ch_ok ? in_ch : '0;
  assign acc_rd    = acc_q[ch_idx];

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !rst && ((state_q == ST_EMPTY) || out_ready);
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;

  // ACC reuses the adder: accumulator is operand A, in_a is operand B.
  assign core_a    = (op == OP_ACC) ? acc_rd : in_a;
  assign core_b    = (op == OP_ACC) ? in_a : in_b;
  assign core_sub  = (op == OP_SUB);

  accum_alu_core #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_core (
    .a_i   (core_a),
    .b_i   (core_b),
    .sub_i (core_sub),
    .res_o (core_res),
    .ovf_o (core_ovf)
  );

  always_comb begin
    res_data  = '0;
    res_ovf   = 1'b0;
    acc_we    = 1'b0;
    acc_wdata = '0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        res_data = core_res;
        res_ovf  = core_ovf;
      end
      OP_ACC: begin
        if (ch_ok) begin
          res_data  = core_res;
          res_ovf   = core_ovf;
          acc_we    = 1'b1;
          acc_wdata = core_res;
        end else begin
          res_ovf = 1'b1;
        end
      end
      OP_CLR: begin
        if (ch_ok) begin
          acc_we = 1'b1;
        end else begin
          res_ovf = 1'b1;
        end
      end
      default: begin
        res_data = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    ch_d    = ch_q;
    unique case (state_q)
      ST_EMPTY: if (xfer_in) state_d = ST_FULL;
      ST_FULL:  if (xfer_out && !xfer_in) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (xfer_in) begin
      data_d = res_data;
      ovf_d  = res_ovf;
      ch_d   = in_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      ch_q    <= ch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else if (xfer_in && acc_we) begin
      acc_q[ch_idx] <= acc_wdata;
    end
  end

  assign out_data = data_q;
  assign out_ovf  = ovf_q;
  assign out_ch   = ch_q;

endmodule

// File: tb/tb_accum_alu.sv
// Two instances (wrap/4 channels and saturate/3 channels) share one stimulus
// stream; expected results are queued on acceptance and checked at the output.
module tb_accum_alu;

  localparam logic [1:0] A_ADD = 2'd0;
  localparam logic [1:0] A_SUB = 2'd1;
  localparam logic [1:0] A_ACC = 2'd2;
  localparam logic [1:0] A_CLR = 2'd3;

  typedef struct {
    logic [1:0] op;
    logic [1:0] ch;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e0;
    logic       o0;
    logic [7:0] e1;
    logic       o1;
  } vec_t;

  typedef struct {
    logic [7:0] d0;
    logic       o0;
    logic [7:0] d1;
    logic       o1;
    logic [1:0] ch;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_op = '0;
  logic [1:0] in_ch = '0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_ready = 1'b0;

  logic       rdy0, val0, ovf0, rdy1, val1, ovf1;
  logic [7:0] dat0, dat1;
  logic [1:0] och0, och1;

  int   checks = 0;
  int   failures = 0;
  bit   known = 1'b0;
  exp_t q[$];
  vec_t tbl[20];

  always #5 clk = ~clk;

  accum_alu #(.WIDTH(8), .NUM_CH(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_op(in_op), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
    .out_valid(val0), .out_ready(out_ready), .out_data(dat0),
    .out_ovf(ovf0), .out_ch(och0)
  );

  accum_alu #(.WIDTH(8), .NUM_CH(3), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_op(in_op), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
    .out_valid(val1), .out_ready(out_ready), .out_data(dat1),
    .out_ovf(ovf1), .out_ch(och1)
  );

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [1:0] op,
                      input logic [1:0] ch, input logic [7:0] a,
                      input logic [7:0] b, input bit rdy,
                      input logic [7:0] e0, input bit o0,
                      input logic [7:0] e1, input bit o1);
    bit   exp_rdy, xin, xout;
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_op = op; in_ch = ch; in_a = a; in_b = b;
    out_ready = rdy;
    #1;
    exp_rdy = !r && ((q.size() == 0) || rdy);
    chk("in_ready_wrap", int'(rdy0), int'(exp_rdy));
    chk("in_ready_sat", int'(rdy1), int'(exp_rdy));
    if (known) begin
      chk("out_valid_wrap", int'(val0), int'(q.size() != 0));
      chk("out_valid_sat", int'(val1), int'(q.size() != 0));
      if (q.size() != 0) begin
        chk("data_wrap", int'(dat0), int'(q[0].d0));
        chk("ovf_wrap", int'(ovf0), int'(q[0].o0));
        chk("ch_wrap", int'(och0), int'(q[0].ch));
        chk("data_sat", int'(dat1), int'(q[0].d1));
        chk("ovf_sat", int'(ovf1), int'(q[0].o1));
        chk("ch_sat", int'(och1), int'(q[0].ch));
      end
    end
    xin  = v && exp_rdy;
    xout = (q.size() != 0) && rdy;
    if (r) begin
      q.delete();
    end else begin
      if (xout) void'(q.pop_front());
      if (xin) begin
        e.d0 = e0; e.o0 = o0; e.d1 = e1; e.o1 = o1; e.ch = ch;
        q.push_back(e);
      end
    end
    @(posedge clk);
    if (r) known = 1'b1;
  endtask

  task automatic reset_check();
    #1;
    chk("rst_valid_wrap", int'(val0), 0);
    chk("rst_data_wrap", int'(dat0), 0);
    chk("rst_ovf_wrap", int'(ovf0), 0);
    chk("rst_ch_wrap", int'(och0), 0);
    chk("rst_valid_sat", int'(val1), 0);
    chk("rst_data_sat", int'(dat1), 0);
    chk("rst_ovf_sat", int'(ovf1), 0);
    chk("rst_ch_sat", int'(och1), 0);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, A_ADD, 2'd0, 8'd0, 8'd0, rdy, 8'd0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    //           op     ch    a       b       wrap: data ovf  sat: data ovf
    tbl[0]  = '{A_ADD, 2'd1, 8'd200, 8'd100, 8'd44,  1'b1, 8'd255, 1'b1};
    tbl[1]  = '{A_SUB, 2'd2, 8'd5,   8'd9,   8'd252, 1'b1, 8'd0,   1'b1};
    tbl[2]  = '{A_SUB, 2'd3, 8'd9,   8'd5,   8'd4,   1'b0, 8'd4,   1'b0};
    tbl[3]  = '{A_ADD, 2'd0, 8'd3,   8'd4,   8'd7,   1'b0, 8'd7,   1'b0};
    tbl[4]  = '{A_ACC, 2'd2, 8'd10,  8'd99,  8'd10,  1'b0, 8'd10,  1'b0};
    tbl[5]  = '{A_ACC, 2'd2, 8'd10,  8'd0,   8'd20,  1'b0, 8'd20,  1'b0};
    tbl[6]  = '{A_ACC, 2'd2, 8'd10,  8'd0,   8'd30,  1'b0, 8'd30,  1'b0};
    tbl[7]  = '{A_CLR, 2'd2, 8'd77,  8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
    tbl[8]  = '{A_ACC, 2'd1, 8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
    tbl[9]  = '{A_ACC, 2'd3, 8'd1,   8'd0,   8'd1,   1'b0, 8'd0,   1'b1};
    tbl[10] = '{A_ACC, 2'd3, 8'd1,   8'd0,   8'd2,   1'b0, 8'd0,   1'b1};
    tbl[11] = '{A_ACC, 2'd0, 8'd250, 8'd0,   8'd250, 1'b0, 8'd250, 1'b0};
    tbl[12] = '{A_ACC, 2'd0, 8'd10,  8'd0,   8'd4,   1'b1, 8'd255, 1'b1};
    tbl[13] = '{A_ACC, 2'd0, 8'd0,   8'd0,   8'd4,   1'b0, 8'd255, 1'b0};
    tbl[14] = '{A_ADD, 2'd2, 8'd255, 8'd1,   8'd0,   1'b1, 8'd255, 1'b1};
    tbl[15] = '{A_ADD, 2'd1, 8'd255, 8'd0,   8'd255, 1'b0, 8'd255, 1'b0};
    tbl[16] = '{A_SUB, 2'd0, 8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
    tbl[17] = '{A_SUB, 2'd3, 8'd0,   8'd255, 8'd1,   1'b1, 8'd0,   1'b1};
    tbl[18] = '{A_CLR, 2'd3, 8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   1'b1};
    tbl[19] = '{A_ACC, 2'd3, 8'd5,   8'd0,   8'd5,   1'b0, 8'd0,   1'b1};

    step(1'b1, 1'b0, A_ADD, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, A_ACC, 2'd1, 8'd9, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
    reset_check();

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, tbl[i].op, tbl[i].ch, tbl[i].a, tbl[i].b, 1'b1,
           tbl[i].e0, tbl[i].o0, tbl[i].e1, tbl[i].o1);
    end
    idle(1'b1);

    // Stall: result held, second ACC blocked until the consumer returns.
    step(1'b0, 1'b1, A_ADD, 2'd1, 8'd3, 8'd4, 1'b1, 8'd7, 1'b0, 8'd7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, A_ACC, 2'd1, 8'd9, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    end
    step(1'b0, 1'b1, A_ACC, 2'd1, 8'd9, 8'd0, 1'b1, 8'd9, 1'b0, 8'd9, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Reset while FULL with a further ACC presented.
    step(1'b0, 1'b1, A_ACC, 2'd2, 8'd7, 8'd0, 1'b1, 8'd7, 1'b0, 8'd7, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b1, A_ACC, 2'd2, 8'd1, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    reset_check();
    step(1'b0, 1'b1, A_ACC, 2'd2, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, A_ACC, 2'd0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, A_ACC, 2'd1, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, A_ACC, 2'd3, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
